estimador_mvrow_caller: RTL and testbench
=========================================

Name: estimador_mvrow_caller

Overview:
- Caller-side controller for the mvmult row pipeline, which uses an ap_ctrl_hs handshake with three 21-bit results, each carrying its own ap_vld strobe.
- Accepts one scalar from an upstream valid/ready stream and drives it as the callee argument.
- Issues ap_start and holds it until ap_ready, then captures the three results on their vld strobes.
- Serializes the results downstream as a 3-beat valid/ready stream; sits between the estimator sequencer and the row-pipeline instance.

Parameters:
- W, 21, data width of scalar argument and of each result.
- TIMEOUT, 64, max cycles in WAIT before abort; must be >= 4.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream scalar valid.
- in_ready  out  1  upstream ready.
- in_data  in  W  scalar (signed Q-format, passed through unchanged).
- callee_start  out  1  ap_start to row pipeline.
- callee_ready  in  1  ap_ready from row pipeline.
- callee_done  in  1  ap_done from row pipeline.
- callee_arg  out  W  argument to row pipeline.
- callee_out0, callee_out1, callee_out2  in  W each  results 0..2.
- callee_vld0, callee_vld1, callee_vld2  in  1 each  ap_vld for results 0..2.
- out_valid  out  1  downstream valid.
- out_ready  in  1  downstream ready.
- out_data  out  W  result beat.
- out_idx  out  2  beat index 0..2.
- out_last  out  1  high on beat 2.
- err_missing  out  1  1-cycle pulse: done seen with fewer than 3 results captured.
- err_timeout  out  1  1-cycle pulse: WAIT aborted.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release) puts the block in state IDLE:
  - callee_start=0, callee_arg=0, out_valid=0, out_idx=0, out_last=0, out_data=0.
  - err_missing=0, err_timeout=0, busy=0.
  - Result regs and capture bits cleared; timeout counter cleared.
  - in_ready=1, since it is combinational from state==IDLE.
- The FSM has four states: IDLE, START, WAIT, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into callee_arg, clear capture bits and results, go to START.
- START:
  - callee_start=1, held steady until callee_ready=1 in the same cycle.
  - When callee_ready=1: next state WAIT, callee_start drops next cycle, timeout counter cleared.
  - callee_arg is stable from the START entry cycle until the return to IDLE.
- Capture (applies in START and WAIT):
  - Every cycle with callee_vldN=1, register callee_outN and set capN.
  - A later vld for the same N overwrites the stored value.
- WAIT:
  - Counter increments each cycle.
  - On callee_done=1: vld strobes in the same cycle are captured and counted, and the next state is EMIT.
  - If capN for all N (counting same-cycle strobes) are not all 1 on done, pulse err_missing the next cycle. Uncaptured results emit as 0.
  - If the counter reaches TIMEOUT-1 without done: pulse err_timeout, go to IDLE, emit nothing.
- Done in START: if callee_done arrives while still in START (same cycle as callee_ready), handle it as WAIT's done and go directly to EMIT.
- EMIT:
  - out_valid=1, out_data=result[out_idx], out_last=(out_idx==2).
  - On out_valid&out_ready: idx increments. After beat 2, go to IDLE with idx=0.
  - out_data, out_idx and out_last are stable while out_valid=1 and out_ready=0.
- Latency from accepted input to first out_valid is 2 + (callee done latency) cycles: START cycle(s) plus WAIT cycles, out_valid registered.
- Back-to-back operation: a new input is accepted only in IDLE, i.e. the cycle after the final beat handshake. No overlap of calls.
- in_ready=0 in START, WAIT and EMIT; upstream data is held by the source.
- Reset mid-operation: immediate return to IDLE; any partial call is abandoned and callee_start drops asynchronously.
- Callee signals arriving in IDLE or EMIT (stray vld/done) are ignored.

Test Plan:
- Nominal call:
  - Stimulus: in_data=21'd100; callee_ready asserts 2 cycles after start; vld0..2 and done in the same cycle with out0=21'd747900, out1=21'd4700, out2=21'd0; out_ready tied 1.
  - Required: beats (747900, idx0), (4700, idx1), (0, idx2, last); no error pulses; in_ready returns 1 the cycle after beat 2.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles on beat 1.
  - Required: out_data/out_idx held at 4700/1; no beat lost or duplicated.
- Missing vld:
  - Stimulus: done with only vld0 and vld2 ever asserted.
  - Required: err_missing single pulse; beat 1 data=0; beats 0 and 2 correct.
- Timeout:
  - Stimulus: callee never asserts done.
  - Required: err_timeout pulse at TIMEOUT cycles after WAIT entry; FSM back in IDLE; no out_valid.
- Start hold:
  - Stimulus: callee_ready delayed 7 cycles.
  - Required: callee_start high for exactly those cycles, then 0; callee_arg constant throughout.
- Reset mid-WAIT:
  - Stimulus: drop ap_rst_n mid-WAIT.
  - Required: all outputs at reset values immediately; a subsequent call completes normally.

Source files
------------

// File: rtl/estimador_mvrow_caller.sv
// Caller-side controller for the mvmult row pipeline. It takes one scalar in and issues an
// ap_ctrl_hs call. It then captures the three ap_vld results and replays them as a 3-beat stream.
module estimador_mvrow_caller #(
  parameter int W       = 21,
  parameter int TIMEOUT = 64
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         callee_start,
  input  logic         callee_ready,
  input  logic         callee_done,
  output logic [W-1:0] callee_arg,
  input  logic [W-1:0] callee_out0,
  input  logic [W-1:0] callee_out1,
  input  logic [W-1:0] callee_out2,
  input  logic         callee_vld0,
  input  logic         callee_vld1,
  input  logic         callee_vld2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         err_missing,
  output logic         err_timeout,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_EMIT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   arg_q;
  logic [W-1:0]   res_q [3];
  logic [2:0]     cap_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     idx_q;
  logic           err_missing_q, err_timeout_q;

  logic [W-1:0]   cout [3];
  logic [2:0]     vld_vec;
  logic           accept, capturing, done_now, timeout_hit, beat;

  assign cout[0] = callee_out0;
  assign cout[1] = callee_out1;
  assign cout[2] = callee_out2;
  assign vld_vec = {callee_vld2, callee_vld1, callee_vld0};

  assign accept      = (state_q == S_IDLE) && in_valid;
  assign capturing   = (state_q == S_START) || (state_q == S_WAIT);
  // A done that lands together with ready in START counts as the WAIT done.
  assign done_now    = ((state_q == S_WAIT) && callee_done) ||
                       ((state_q == S_START) && callee_ready && callee_done);
  assign timeout_hit = (state_q == S_WAIT) && !callee_done && (cnt_q == CW'(TIMEOUT - 1));
  assign beat        = (state_q == S_EMIT) && out_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_START;
      S_START: if (callee_ready) state_d = callee_done ? S_EMIT : S_WAIT;
      S_WAIT:  if (callee_done) state_d = S_EMIT;
               else if (timeout_hit) state_d = S_IDLE;
      S_EMIT:  if (out_ready && (idx_q == 2'd2)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    callee_start = (state_q == S_START);
    out_valid    = (state_q == S_EMIT);
    busy         = (state_q != S_IDLE);
    out_idx      = idx_q;
    out_last     = (state_q == S_EMIT) && (idx_q == 2'd2);
    out_data     = '0;
    if (state_q == S_EMIT) out_data = res_q[idx_q];
    callee_arg   = arg_q;
    err_missing  = err_missing_q;
    err_timeout  = err_timeout_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      arg_q         <= '0;
      cap_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      err_missing_q <= 1'b0;
      err_timeout_q <= 1'b0;
      for (int i = 0; i < 3; i++) res_q[i] <= '0;
    end else begin
      if (accept) begin
        arg_q <= in_data;
        cap_q <= '0;
        for (int i = 0; i < 3; i++) res_q[i] <= '0;
      end else if (capturing) begin
        for (int i = 0; i < 3; i++) begin
          if (vld_vec[i]) begin
            res_q[i] <= cout[i];
            cap_q[i] <= 1'b1;
          end
        end
      end

      if ((state_q == S_START) && callee_ready) cnt_q <= '0;
      else if (state_q == S_WAIT)               cnt_q <= cnt_q + CW'(1);

      // Same-cycle strobes count towards completeness of the result set.
      err_missing_q <= done_now && ((cap_q | vld_vec) != 3'b111);
      err_timeout_q <= timeout_hit;

      if (beat) idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_estimador_mvrow_caller.sv
// Bench for estimador_mvrow_caller: a vector table of calls driven against a callee model.
// Expected beats are queued at call acceptance and checked as the DUT emits them.
module tb_estimador_mvrow_caller;
  localparam int W  = 21;
  localparam int TO = 16;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_data;
  logic         callee_start, callee_ready, callee_done;
  logic [W-1:0] callee_arg, callee_out0, callee_out1, callee_out2;
  logic         callee_vld0, callee_vld1, callee_vld2;
  logic         out_valid, out_ready, out_last;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         err_missing, err_timeout, busy;

  estimador_mvrow_caller #(.W(W), .TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .callee_start(callee_start), .callee_ready(callee_ready), .callee_done(callee_done),
    .callee_arg(callee_arg),
    .callee_out0(callee_out0), .callee_out1(callee_out1), .callee_out2(callee_out2),
    .callee_vld0(callee_vld0), .callee_vld1(callee_vld1), .callee_vld2(callee_vld2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .err_missing(err_missing), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [W-1:0] arg;
    int           rdy;      // START cycle (0-based) on which callee_ready is raised
    int           dn;       // -1: never done; 0: done with ready; k: done on WAIT cycle k-1
    logic [2:0]   vld;
    logic [W-1:0] r0, r1, r2;
    bit           pre;      // strobe garbage on the ready cycle, overwritten at done
    int           bp_beat;
    int           bp_len;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    failures = 0;
  int    cur = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s actual=%0d required=%0d", cur, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_callee(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c);
    callee_vld0 = m[0]; callee_vld1 = m[1]; callee_vld2 = m[2];
    callee_out0 = a;    callee_out1 = b;    callee_out2 = c;
  endtask

  task automatic clear_callee();
    callee_ready = 0;
    callee_done  = 0;
    set_callee(3'b000, '0, '0, '0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", callee_start, 0);
    chk("rst_arg", callee_arg, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_missing", err_missing, 0);
    chk("rst_err_timeout", err_timeout, 0);
  endtask

  task automatic run_call(input vec_t v);
    int    n, starts, b, held, guard;
    beat_t e;
    logic [W-1:0] r [3];
    r[0] = v.r0; r[1] = v.r1; r[2] = v.r2;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_data = v.arg;
    tick();
    in_valid = 0; in_data = ~v.arg;
    if (v.dn >= 0) begin
      for (int i = 0; i < 3; i++) begin
        e.data = v.vld[i] ? r[i] : '0;
        e.idx  = 2'(i);
        e.last = (i == 2);
        q.push_back(e);
      end
    end
    starts = 0;
    for (int c = 0; c <= v.rdy; c++) begin
      if (callee_start) starts++;
      chk("arg_start", callee_arg, v.arg);
      chk("in_ready_start", in_ready, 0);
      if (c == v.rdy) begin
        callee_ready = 1;
        if (v.pre) set_callee(v.vld, ~v.r0, ~v.r1, ~v.r2);
        if (v.dn == 0) begin
          callee_done = 1;
          set_callee(v.vld, v.r0, v.r1, v.r2);
        end
      end
      tick();
      clear_callee();
    end
    chk("start_cycles", starts, v.rdy + 1);
    chk("start_drop", callee_start, 0);
    if (v.dn < 0) begin
      for (int k = 1; k <= TO + 2; k++) begin
        if (k < TO) chk("arg_wait", callee_arg, v.arg);
        tick();
        chk("timeout_pulse", err_timeout, (k == TO));
        chk("timeout_no_valid", out_valid, 0);
        if (k == TO) chk("timeout_idle", busy, 0);
      end
      $display("call vec%0d arg=%0d timeout", cur, v.arg);
      return;
    end
    for (int c = 0; c < v.dn; c++) begin
      chk("arg_wait", callee_arg, v.arg);
      chk("wait_no_valid", out_valid, 0);
      if (c == v.dn - 1) begin
        callee_done = 1;
        set_callee(v.vld, v.r0, v.r1, v.r2);
      end
      tick();
      clear_callee();
    end
    chk("err_missing", err_missing, (v.vld != 3'b111));
    b = 0; held = 0; guard = 0;
    while (b < 3 && guard < 20) begin
      guard++;
      if (!out_valid) begin
        chk("out_valid", out_valid, 1);
        break;
      end
      e = q[0];
      chk("out_data", out_data, e.data);
      chk("out_idx", out_idx, e.idx);
      chk("out_last", out_last, e.last);
      chk("emit_err_timeout", err_timeout, 0);
      if (guard > 1) chk("missing_one_cycle", err_missing, 0);
      if (b == v.bp_beat && held < v.bp_len) begin
        out_ready = 0;
        held++;
        tick();
      end else begin
        out_ready = 1;
        void'(q.pop_front());
        tick();
        out_ready = 0;
        b++;
      end
    end
    chk("beats_done", b, 3);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    q.delete();
    $display("call vec%0d arg=%0d vld=%b beats=%0d", cur, v.arg, v.vld, b);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{21'd100,    2,  3, 3'b111, 21'd747900, 21'd4700, 21'd0, 1'b0, -1, 0};
    vecs[1] = '{21'd101,    0,  1, 3'b111, 21'd747900, 21'd4700, 21'd0, 1'b0,  1, 5};
    vecs[2] = '{21'd5,      1,  2, 3'b101, 21'd11,     21'd22,   21'd33, 1'b0, -1, 0};
    vecs[3] = '{21'h1FFFFF, 1,  0, 3'b111, 21'h100000, 21'h0FFFFF, 21'h1FFFFF, 1'b0, -1, 0};
    vecs[4] = '{21'd777,    7,  2, 3'b111, 21'd1,      21'd2,    21'd3,  1'b0, -1, 0};
    vecs[5] = '{21'd9,      1, -1, 3'b000, 21'd0,      21'd0,    21'd0,  1'b0, -1, 0};
    vecs[6] = '{21'd42,     1,  4, 3'b111, 21'd123,    21'd456,  21'd789, 1'b1, 2, 2};
    vecs[7] = '{21'd3,      0,  0, 3'b011, 21'd70000,  21'd80000, 21'd5, 1'b0, 0, 3};

    ap_rst_n = 0; in_valid = 0; in_data = '0; out_ready = 0;
    clear_callee();
    tick(); tick();
    check_reset_outputs();
    @(negedge ap_clk) ap_rst_n = 1;
    tick();

    for (int i = 0; i < 8; i++) begin
      cur = i;
      run_call(vecs[i]);
    end

    cur = 100;
    in_valid = 1; in_data = 21'd55;
    tick();
    in_valid = 0;
    chk("midstart_start", callee_start, 1);
    ap_rst_n = 0;
    #1;
    check_reset_outputs();
    @(negedge ap_clk) ap_rst_n = 1;
    tick();

    cur = 101;
    in_valid = 1; in_data = 21'd77;
    tick();
    in_valid = 0; callee_ready = 1;
    tick();
    clear_callee();
    tick(); tick(); tick();
    chk("midwait_busy", busy, 1);
    ap_rst_n = 0;
    #1;
    check_reset_outputs();
    $display("call vec%0d reset mid-WAIT", cur);
    @(negedge ap_clk) ap_rst_n = 1;
    tick();

    cur = 102;
    run_call(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
